// File: rtl/mem_req_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_req_ctrl
//  Brief    : Data-memory request controller between execute and an SRAM-like
//             bus (req/addr_ok/data_ok). Tracks in-flight accesses in order,
//             aligns/extends load data, raises ALE for misaligned accesses and
//             drops responses of requests killed by a flush.
//  Revision : 1.0  initial release
// ============================================================================
module mem_req_ctrl #(
    parameter int DATA_W          = 32,
    parameter int ADDR_W          = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               in_wr,
    input  logic [1:0]                         in_size,
    input  logic                               in_sign,
    input  logic [ADDR_W-1:0]                  in_addr,
    input  logic [DATA_W-1:0]                  in_wdata,
    input  logic                               flush,
    output logic                               data_sram_req,
    output logic                               data_sram_wr,
    output logic [1:0]                         data_sram_size,
    output logic [DATA_W/8-1:0]                data_sram_wstrb,
    output logic [ADDR_W-1:0]                  data_sram_addr,
    output logic [DATA_W-1:0]                  data_sram_wdata,
    input  logic                               data_sram_addr_ok,
    input  logic                               data_sram_data_ok,
    input  logic [DATA_W-1:0]                  data_sram_rdata,
    output logic                               rsp_valid,
    output logic                               rsp_wr,
    output logic                               rsp_ale,
    output logic [DATA_W-1:0]                  rsp_rdata,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
    output logic                               proto_err
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);

    // In-flight queue: payload arrays plus a per-entry discard flag
    logic                 q_wr   [MAX_OUTSTANDING];
    logic [1:0]           q_size [MAX_OUTSTANDING];
    logic                 q_sign [MAX_OUTSTANDING];
    logic [OFF_W-1:0]     q_off  [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] q_disc;

    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic                 ale_pending;
    logic                 ale_wr;
    logic                 proto_err_r;

    logic [2:0]           align_mask;
    logic                 misaligned;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 ale_accept;
    logic                 ale_rsp;
    logic                 load_rsp;
    logic                 head_wr;
    logic [1:0]           head_size;
    logic                 head_sign;
    logic [OFF_W-1:0]     head_off;
    logic [DATA_W-1:0]    shifted;
    logic [DATA_W-1:0]    ext_mask;
    logic                 ext_sbit;
    logic [DATA_W-1:0]    load_data;
    logic [NB-1:0]        strb_base;

    // Low address bits that must be zero for a naturally aligned access
    always_comb begin
        align_mask = 3'b111;
        case (in_size)
            2'd0:    align_mask = 3'b000;
            2'd1:    align_mask = 3'b001;
            2'd2:    align_mask = 3'b011;
            default: align_mask = 3'b111;
        endcase
    end

    assign misaligned = |(in_addr[2:0] & align_mask);
    assign full       = (count == CNT_FULL);
    assign empty      = (count == '0);

    // Request/acceptance handshake; full uses the registered count only
    assign data_sram_req = in_valid & ~misaligned & ~full & ~flush & ~ale_pending;
    assign push          = data_sram_req & data_sram_addr_ok;
    assign ale_accept    = in_valid & misaligned & empty & ~ale_pending & ~flush;
    assign in_ready      = push | ale_accept;
    assign pop           = data_sram_data_ok & ~empty;

    assign data_sram_wr   = in_wr;
    assign data_sram_size = in_size;
    assign data_sram_addr = in_addr;

    // Store data replicated per lane and byte strobes positioned at the offset
    always_comb begin
        data_sram_wdata = in_wdata;
        strb_base       = '1;
        case (in_size)
            2'd0: begin
                data_sram_wdata = {NB{in_wdata[7:0]}};
                strb_base       = NB'(1);
            end
            2'd1: begin
                data_sram_wdata = {(NB/2){in_wdata[15:0]}};
                strb_base       = NB'(3);
            end
            2'd2: begin
                data_sram_wdata = {(DATA_W/32){in_wdata[31:0]}};
                strb_base       = NB'(15);
            end
            default: begin
                data_sram_wdata = in_wdata;
                strb_base       = '1;
            end
        endcase
        data_sram_wstrb = in_wr ? (strb_base << in_addr[OFF_W-1:0]) : '0;
    end

    assign head_wr   = q_wr[rd_ptr];
    assign head_size = q_size[rd_ptr];
    assign head_sign = q_sign[rd_ptr];
    assign head_off  = q_off[rd_ptr];

    // Load data: shift the addressed lane down, mask to size, then extend
    always_comb begin
        shifted  = data_sram_rdata >> {head_off, 3'b000};
        ext_mask = '1;
        ext_sbit = shifted[DATA_W-1];
        case (head_size)
            2'd0: begin
                ext_mask = DATA_W'(8'hFF);
                ext_sbit = shifted[7];
            end
            2'd1: begin
                ext_mask = DATA_W'(16'hFFFF);
                ext_sbit = shifted[15];
            end
            2'd2: begin
                ext_mask = DATA_W'(32'hFFFF_FFFF);
                ext_sbit = shifted[31];
            end
            default: begin
                ext_mask = '1;
                ext_sbit = shifted[DATA_W-1];
            end
        endcase
        load_data = (shifted & ext_mask) | ((head_sign & ext_sbit) ? ~ext_mask : '0);
    end

    // Response mux: ALE takes its one-cycle slot, otherwise a live popped head
    assign ale_rsp   = ale_pending & ~flush;
    assign load_rsp  = pop & ~q_disc[rd_ptr] & ~flush;
    assign rsp_valid = ale_rsp | load_rsp;
    assign rsp_ale   = ale_rsp;
    assign rsp_wr    = ale_rsp ? ale_wr : (load_rsp & head_wr);
    assign rsp_rdata = (load_rsp & ~ale_rsp & ~head_wr) ? load_data : '0;

    assign outstanding = count;
    assign proto_err   = proto_err_r;

    // Queue control, ALE tracking and sticky protocol error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            q_disc      <= '0;
            ale_pending <= 1'b0;
            ale_wr      <= 1'b0;
            proto_err_r <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Flush marks every entry dead; stale flags on free slots are
            // cleared again when the slot is next written
            if (flush) begin
                q_disc <= '1;
            end else if (push) begin
                q_disc[wr_ptr] <= 1'b0;
            end
            ale_pending <= ale_accept;
            if (ale_accept) begin
                ale_wr <= in_wr;
            end
            if (data_sram_data_ok && empty) begin
                proto_err_r <= 1'b1;
            end
        end
    end

    // Queue payload capture; contents are only meaningful while counted
    always_ff @(posedge clk) begin
        if (push) begin
            q_wr[wr_ptr]   <= in_wr;
            q_size[wr_ptr] <= in_size;
            q_sign[wr_ptr] <= in_sign;
            q_off[wr_ptr]  <= in_addr[OFF_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_req_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_req_ctrl
//  Brief    : Directed self-checking bench for mem_req_ctrl with an ordered
//             response scoreboard (DATA_W=32, MAX_OUTSTANDING=2).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_req_ctrl;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_wr;
    logic [1:0]  in_size;
    logic        in_sign;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        flush;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        rsp_valid;
    logic        rsp_wr;
    logic        rsp_ale;
    logic [31:0] rsp_rdata;
    logic [1:0]  outstanding;
    logic        proto_err;

    typedef struct {
        logic        wr;
        logic        ale;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    mem_req_ctrl #(
        .DATA_W(32),
        .ADDR_W(32),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_wr(in_wr),
        .in_size(in_size),
        .in_sign(in_sign),
        .in_addr(in_addr),
        .in_wdata(in_wdata),
        .flush(flush),
        .data_sram_req(data_sram_req),
        .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size),
        .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok),
        .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .rsp_valid(rsp_valid),
        .rsp_wr(rsp_wr),
        .rsp_ale(rsp_ale),
        .rsp_rdata(rsp_rdata),
        .outstanding(outstanding),
        .proto_err(proto_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: any response must match the oldest expectation
    task automatic mon();
        exp_t e;
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_wr", 64'(rsp_wr), 64'(e.wr));
                chk("rsp_ale", 64'(rsp_ale), 64'(e.ale));
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e.data));
            end
        end
    endtask

    task automatic half();
        @(negedge clk);
        mon();
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            half();
            nxt();
        end
    endtask

    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] e_strb, input logic [31:0] e_wdata,
                         input string tag);
        in_valid = 1'b1; in_wr = wr; in_size = sz; in_sign = sg;
        in_addr = a; in_wdata = wd; data_sram_addr_ok = 1'b1;
        half();
        chk({tag, "_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_req"}, 64'(data_sram_req), 64'd1);
        chk({tag, "_wstrb"}, 64'(data_sram_wstrb), 64'(e_strb));
        chk({tag, "_wdata"}, 64'(data_sram_wdata), 64'(e_wdata));
        nxt();
        in_valid = 1'b0; data_sram_addr_ok = 1'b0; in_wdata = '0;
    endtask

    task automatic respond(input logic [31:0] rd);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rd;
        half();
        nxt();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
    endtask

    task automatic push_exp(input logic wr, input logic ale, input logic [31:0] d);
        exp_t e;
        e.wr = wr; e.ale = ale; e.data = d;
        exp_q.push_back(e);
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_wr = 1'b0; in_size = 2'd0; in_sign = 1'b0;
        in_addr = '0; in_wdata = '0; flush = 1'b0; data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b0; data_sram_rdata = '0;

        // Reset state
        #3;
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_req", 64'(data_sram_req), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_outstanding", 64'(outstanding), 64'd0);
        chk("rst_proto_err", 64'(proto_err), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        nxt();

        // Word load, response two cycles later
        push_exp(1'b0, 1'b0, 32'hDEADBEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h1004, 32'h0, 4'b0000, 32'h0, "ldw");
        chk("ldw_outstanding", 64'(outstanding), 64'd1);
        idle(1);
        respond(32'hDEADBEEF);
        chk("ldw_drained", 64'(outstanding), 64'd0);

        // Byte loads signed/unsigned, half load signed
        push_exp(1'b0, 1'b0, 32'hFFFFFF80);
        issue(1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 4'b0000, 32'h0, "ldb_s");
        respond(32'h80FF1234);
        push_exp(1'b0, 1'b0, 32'h00000080);
        issue(1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 4'b0000, 32'h0, "ldb_u");
        respond(32'h80FF1234);
        push_exp(1'b0, 1'b0, 32'hFFFF80FF);
        issue(1'b0, 2'd1, 1'b1, 32'h1002, 32'h0, 4'b0000, 32'h0, "ldh_s");
        respond(32'h80FF1234);

        // Stores: half and byte lane replication/strobes
        push_exp(1'b1, 1'b0, 32'h0);
        issue(1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000ABCD, 4'b1100, 32'hABCDABCD, "sth");
        respond(32'h12345678);
        push_exp(1'b1, 1'b0, 32'h0);
        issue(1'b1, 2'd0, 1'b0, 32'h2001, 32'h0000005A, 4'b0010, 32'h5A5A5A5A, "stb");
        respond(32'h0);

        // Misaligned word store: no request, ALE exactly one cycle later
        in_valid = 1'b1; in_wr = 1'b1; in_size = 2'd2; in_addr = 32'h2006;
        in_wdata = 32'h11223344; data_sram_addr_ok = 1'b1;
        half();
        chk("ale_req", 64'(data_sram_req), 64'd0);
        chk("ale_ready", 64'(in_ready), 64'd1);
        push_exp(1'b1, 1'b1, 32'h0);
        nxt();
        in_valid = 1'b0; data_sram_addr_ok = 1'b0;
        half();
        chk("ale_rsp_seen", 64'(exp_q.size()), 64'd0);
        nxt();
        idle(1);

        // Three back-to-back loads with MAX_OUTSTANDING=2
        push_exp(1'b0, 1'b0, 32'h11111111);
        issue(1'b0, 2'd2, 1'b0, 32'h3000, 32'h0, 4'b0000, 32'h0, "bb0");
        push_exp(1'b0, 1'b0, 32'h22222222);
        issue(1'b0, 2'd2, 1'b0, 32'h3004, 32'h0, 4'b0000, 32'h0, "bb1");
        in_valid = 1'b1; in_wr = 1'b0; in_size = 2'd2; in_addr = 32'h3008;
        data_sram_addr_ok = 1'b1;
        half();
        chk("bb2_held_req", 64'(data_sram_req), 64'd0);
        chk("bb2_held_ready", 64'(in_ready), 64'd0);
        chk("bb_full", 64'(outstanding), 64'd2);
        nxt();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h11111111;
        half();
        chk("bb2_pop_cycle_req", 64'(data_sram_req), 64'd0);
        nxt();
        data_sram_data_ok = 1'b0; data_sram_rdata = '0;
        push_exp(1'b0, 1'b0, 32'h33333333);
        half();
        chk("bb2_issue_req", 64'(data_sram_req), 64'd1);
        chk("bb2_issue_ready", 64'(in_ready), 64'd1);
        nxt();
        in_valid = 1'b0; data_sram_addr_ok = 1'b0;
        respond(32'h22222222);
        respond(32'h33333333);
        chk("bb_drained", 64'(outstanding), 64'd0);
        chk("bb_scb_empty", 64'(exp_q.size()), 64'd0);

        // Flush with two loads in flight: both responses dropped
        issue(1'b0, 2'd2, 1'b0, 32'h4000, 32'h0, 4'b0000, 32'h0, "fl0");
        issue(1'b0, 2'd2, 1'b0, 32'h4004, 32'h0, 4'b0000, 32'h0, "fl1");
        flush = 1'b1;
        half();
        chk("flush_req", 64'(data_sram_req), 64'd0);
        nxt();
        flush = 1'b0;
        chk("flush_count", 64'(outstanding), 64'd2);
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hAAAA5555;
        half();
        chk("flush_rsp0", 64'(rsp_valid), 64'd0);
        nxt();
        chk("flush_count1", 64'(outstanding), 64'd1);
        half();
        chk("flush_rsp1", 64'(rsp_valid), 64'd0);
        nxt();
        data_sram_data_ok = 1'b0;
        chk("flush_count0", 64'(outstanding), 64'd0);
        push_exp(1'b0, 1'b0, 32'h44444444);
        issue(1'b0, 2'd2, 1'b0, 32'h4008, 32'h0, 4'b0000, 32'h0, "fl_new");
        respond(32'h44444444);

        // Flush suppresses a pending ALE response
        in_valid = 1'b1; in_wr = 1'b0; in_size = 2'd1; in_addr = 32'h5001;
        half();
        chk("ale2_ready", 64'(in_ready), 64'd1);
        nxt();
        in_valid = 1'b0; flush = 1'b1;
        half();
        chk("ale2_flushed", 64'(rsp_valid), 64'd0);
        nxt();
        flush = 1'b0;
        idle(1);
        chk("mid_scb_empty", 64'(exp_q.size()), 64'd0);

        // data_ok with empty queue sets a sticky protocol error
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFEF00D;
        half();
        chk("perr_no_rsp", 64'(rsp_valid), 64'd0);
        nxt();
        data_sram_data_ok = 1'b0;
        chk("perr_set", 64'(proto_err), 64'd1);
        chk("perr_no_underflow", 64'(outstanding), 64'd0);
        push_exp(1'b0, 1'b0, 32'h00005678);
        issue(1'b0, 2'd1, 1'b0, 32'h6000, 32'h0, 4'b0000, 32'h0, "perr_ld");
        respond(32'h12345678);
        chk("perr_sticky", 64'(proto_err), 64'd1);

        // Reset mid-transaction clears the queue; stale data_ok flags error
        issue(1'b0, 2'd2, 1'b0, 32'h7000, 32'h0, 4'b0000, 32'h0, "mrst");
        reset = 1'b0;
        #1;
        chk("mrst_count", 64'(outstanding), 64'd0);
        chk("mrst_perr_clr", 64'(proto_err), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        nxt();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h77777777;
        half();
        chk("mrst_no_rsp", 64'(rsp_valid), 64'd0);
        nxt();
        data_sram_data_ok = 1'b0;
        chk("mrst_perr", 64'(proto_err), 64'd1);
        chk("final_scb_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
